// File: rtl/program_counter_stack.sv
// Instruction program counter with a hardware return-address stack for interrupt nesting.
// Optional feature macro PC_NESTED_INT_EN: full RET_STACK_DEPTH nesting; undefined limits to one active handler.
module program_counter_stack #(
  parameter int unsigned  ADDR_WIDTH_MEM  = 16,
  parameter int unsigned  DDR_ADDR_WIDTH  = 28,
  parameter int unsigned  ISA_DEPTH       = 64,
  parameter int unsigned  TOTAL_ISA_DEPTH = 128,
  parameter int unsigned  INT_REGION_BASE = 'hC000,
  parameter int unsigned  JMP_SHIFT       = 3,
  parameter int unsigned  RET_STACK_DEPTH = 4,
  localparam int unsigned LVL_W           = $clog2(RET_STACK_DEPTH) + 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      int_i,
  input  logic                      ret_valid_i,
  input  logic                      ins_inp_valid_i,
  input  logic [DDR_ADDR_WIDTH-1:0] jmp_addr_pc_i,
  input  logic                      ins_cache_rdy_i,
  input  logic [9:0]                load_times_i,
  output logic [ADDR_WIDTH_MEM-1:0] addr_ins_o,
  output logic                      int_ack_o,
  output logic [LVL_W-1:0]          stack_level_o,
  output logic                      stack_ovf_o,
  output logic                      stack_udf_o
);

`ifdef PC_NESTED_INT_EN
  localparam int unsigned EFF_DEPTH = RET_STACK_DEPTH;
  localparam bit          OVF_EN    = 1'b1;
`else
  localparam int unsigned EFF_DEPTH = 1;
  localparam bit          OVF_EN    = 1'b0;
`endif
  localparam int unsigned PTR_W = (EFF_DEPTH > 1) ? $clog2(EFF_DEPTH) : 1;
  localparam int unsigned STK_N = 2 ** PTR_W;
  localparam int unsigned CMP_W = ADDR_WIDTH_MEM + 10;
  localparam logic [ADDR_WIDTH_MEM-1:0] JMP_SENTINEL = {1'b1, {(ADDR_WIDTH_MEM-1){1'b0}}};

  typedef enum logic [1:0] {START, RUN, JUMP, RET_END} state_e;

  state_e                    state_q;
  logic [ADDR_WIDTH_MEM-1:0] addr_q;
  logic                      ack_q;
  logic                      ovf_q;
  logic                      udf_q;
  logic                      int_q;
  logic                      pend_q;
  logic [LVL_W-1:0]          level_q;
  logic [ADDR_WIDTH_MEM-1:0] stack_q [STK_N];

  logic             int_edge_d;
  logic             stk_empty_d;
  logic             stk_full_d;
  logic             inc_ok_d;
  logic [CMP_W-1:0] blk_end_d;
  logic [PTR_W-1:0] push_idx_d;
  logic [PTR_W-1:0] pop_idx_d;

  // Block-end compare is done at full product width so large load_times never wrap.
  always_comb begin
    int_edge_d  = int_i & ~int_q;
    stk_empty_d = (level_q == '0);
    stk_full_d  = (level_q == LVL_W'(EFF_DEPTH));
    push_idx_d  = level_q[PTR_W-1:0];
    pop_idx_d   = PTR_W'(level_q - LVL_W'(1));
    blk_end_d   = CMP_W'(ISA_DEPTH) * CMP_W'(load_times_i);
    inc_ok_d    = ins_inp_valid_i && ins_cache_rdy_i && !ret_valid_i
                  && ((addr_q < ADDR_WIDTH_MEM'(TOTAL_ISA_DEPTH))
                      || (addr_q >= ADDR_WIDTH_MEM'(INT_REGION_BASE)))
                  && (CMP_W'(addr_q) != blk_end_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= START;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      int_q   <= 1'b0;
      pend_q  <= 1'b0;
      level_q <= '0;
      for (int unsigned i = 0; i < STK_N; i++) stack_q[i] <= '0;
    end else begin
      int_q <= int_i;
      ack_q <= 1'b0;
      if (int_edge_d) pend_q <= 1'b1;
      case (state_q)
        START: state_q <= RUN;
        RUN: begin
          // Return outranks interrupt; a blocked interrupt simply stays pending.
          if (ret_valid_i) begin
            if (!stk_empty_d) begin
              addr_q  <= stack_q[pop_idx_d];
              level_q <= level_q - LVL_W'(1);
              state_q <= RET_END;
            end else begin
              udf_q <= 1'b1;
            end
          end else if (pend_q && !stk_full_d) begin
            stack_q[push_idx_d] <= addr_q;
            level_q <= level_q + LVL_W'(1);
            ack_q   <= 1'b1;
            pend_q  <= int_edge_d;
            addr_q  <= JMP_SENTINEL;
            state_q <= JUMP;
          end else begin
            if (pend_q && OVF_EN) ovf_q <= 1'b1;
            if (inc_ok_d) addr_q <= addr_q + ADDR_WIDTH_MEM'(1);
          end
        end
        JUMP: begin
          if (ins_inp_valid_i) begin
            addr_q  <= ADDR_WIDTH_MEM'(jmp_addr_pc_i >> JMP_SHIFT);
            state_q <= RUN;
          end
        end
        RET_END: begin
          if (ins_cache_rdy_i) state_q <= RUN;
        end
        default: state_q <= START;
      endcase
    end
  end

  assign addr_ins_o    = addr_q;
  assign int_ack_o     = ack_q;
  assign stack_level_o = level_q;
  assign stack_ovf_o   = ovf_q;
  assign stack_udf_o   = udf_q;

endmodule
